ultrasonic_scan_n: RTL and testbench
====================================

// Module: ultrasonic_scan_n
// PURPOSE
//  Multi-channel HC-SR04 ranging controller, parametrised successor of the single-sensor block.
//  Fires N_CH sensors one at a time in round-robin order and measures each echo width in cm.
//  Adds per-channel echo timeout, an enable gate and a done/valid strobe.
//  Sits between the sensor pins and the AXI-lite register file of the ultrasonic IP.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency; us tick = CLK_HZ/1_000_000 cycles
//  N_CH        4            number of sensors (1..8)
//  DIST_W      12           distance width in cm per channel
//  TRIG_US     10           trigger pulse width, us
//  GAP_US      60_000       idle gap before each channel's trigger, us
//  TIMEOUT_US  30_000       max wait for echo rise, and max echo-high time, us
// PORTS
//  clk        in   1             system clock, all logic on posedge
//  reset_n    in   1             asynchronous, active-low reset
//  enable     in   1             1 = scanning runs; 0 = abort and park in IDLE
//  echo       in   N_CH          raw echo pins, asynchronous
//  trigger    out  N_CH          trigger pins, at most one high at any time
//  distance   out  N_CH*DIST_W   channel k at [k*DIST_W +: DIST_W], cm
//  timeout    out  N_CH          sticky per channel: 1 = last attempt timed out
//  valid      out  1             one-cycle strobe: channel ch_id finished (distance or timeout)
//  ch_id      out  3             channel currently or last serviced
//  state_dbg  out  3             FSM state, for LED bar
// BEHAVIOUR
//  Reset values: trigger=0, distance=0, timeout=0, valid=0, ch_id=0, state=IDLE.
//  - echo gets a 2-FF synchroniser, then rise/fall detect. Edges are seen 3 clk after the pin moves.
//  - us tick: free-running divider, one-cycle pulse every CLK_HZ/1e6 clk. The us counter only advances on a tick.
//  FSM:
//  - IDLE: enable=1 -> GAP, us counter cleared.
//  - GAP: after GAP_US ticks -> TRIG.
//  - TRIG: trigger[ch_id]=1 for exactly TRIG_US ticks, then 0 -> WAIT_HI, counter cleared.
//  - WAIT_HI: rise on echo[ch_id] -> MEASURE, cm counter cleared.
//    TIMEOUT_US ticks with no rise -> TOUT.
//  - MEASURE: cm counter +1 every 58 ticks while echo high; saturates at 2^DIST_W-1.
//    Fall -> DONE. TIMEOUT_US ticks with echo still high -> TOUT.
//  - DONE: distance[ch_id] <= cm, timeout[ch_id] <= 0, valid=1 for 1 clk -> NEXT.
//  - TOUT: distance[ch_id] kept as is, timeout[ch_id] <= 1, valid=1 for 1 clk -> NEXT.
//  - NEXT: ch_id <= (ch_id==N_CH-1) ? 0 : ch_id+1 -> GAP.
//  Boundary conditions:
//  - enable=0 in any state: next clk trigger=0 and state=IDLE. No distance, timeout or valid update; ch_id kept.
//  - Echo edges on non-selected channels are ignored.
//  - Echo already high on entry to WAIT_HI: no rise is seen, so the attempt times out.
//  - Rise and timeout expiry in the same clk: the rise wins.
//  - Fall and timeout expiry in the same clk: the fall wins (DONE).
//  - reset_n low mid-measurement: all outputs return to reset values immediately.
//  - Latency: fall seen -> distance and valid updated on the same clk edge (DONE state, +1 clk).
// STRUCTURE
//  - Shared header ultrasonic_defs.vh: state encodings (IDLE, GAP, TRIG, WAIT_HI, MEASURE, DONE, TOUT, NEXT)
//    and US_PER_CM=58.
//  - Sub-module us_cm_counter: us tick divider, us counter and cm counter.
//    Inputs: clear, count_en. Outputs: tick, us_cnt, cm (saturating).
//  - Top level holds the synchronisers, FSM, channel mux and output registers.
// TESTING (bench: CLK_HZ=1_000_000, GAP_US=100, TIMEOUT_US=3000, N_CH=4)
//  1. Echo model on ch0 rises 200us after trigger falls, high 580us
//     -> distance[0]=10, valid pulse with ch_id=0, timeout[0]=0.
//  2. Channels 0..3 high 58, 116, 174, 232us
//     -> distances 1, 2, 3, 4 in order; ch_id wraps 3->0; never two trigger bits high.
//  3. ch2 echo never rises -> timeout[2]=1 exactly 3000us after trigger, distance[2] unchanged.
//     Next pass with 290us echo -> distance[2]=5, timeout[2]=0.
//  4. DIST_W=4, echo high 1200us -> distance saturates at 15.
//  5. enable dropped during MEASURE on ch1 -> trigger=0 and IDLE on next clk, no valid.
//     Re-enable -> ch1 re-measured first.
//  6. reset_n pulsed low mid-TRIG -> trigger=0 asynchronously, all distances 0, ch_id=0.

Source files
------------

// File: rtl/ultrasonic_scan_n_pkg.sv
// Shared definitions for the multi-channel ultrasonic ranging controller.
// Holds the FSM state encoding, the echo-time-per-cm constant and a small
// helper used to size counters from the timing parameters.
package ultrasonic_scan_n_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GAP     = 3'd1,
        S_TRIG    = 3'd2,
        S_WAIT_HI = 3'd3,
        S_MEASURE = 3'd4,
        S_DONE    = 3'd5,
        S_TOUT    = 3'd6,
        S_NEXT    = 3'd7
    } scan_state_e;

    // Round-trip echo time for one centimetre of range.
    localparam int US_PER_CM = 58;

    localparam int CH_ID_W = 3;
    localparam int MAX_CH  = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ultrasonic_scan_n_us_cm_counter.sv
// Timebase for the ranging controller.
//   clk, reset_n : system clock, async active-low reset
//   clear        : zero the us counter and the cm counter (wins over counting)
//   count_en     : accumulate echo time into cm
//   tick         : one-cycle pulse every CLK_HZ/1e6 clocks (free running)
//   us_cnt       : ticks since the last clear, saturating
//   cm           : completed 58-tick periods while count_en, saturating
module us_cm_counter
    import ultrasonic_scan_n_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int US_W   = 16,
    parameter int DIST_W = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              count_en,
    output logic              tick,
    output logic [US_W-1:0]   us_cnt,
    output logic [DIST_W-1:0] cm
);

    localparam int DIV   = max_int(CLK_HZ / 1_000_000, 1);
    localparam int DIV_W = max_int($clog2(DIV), 1);
    localparam int SUB_W = $clog2(US_PER_CM);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [US_W-1:0]   us_q, us_d;
    logic [SUB_W-1:0]  sub_q, sub_d;
    logic [DIST_W-1:0] cm_q, cm_d;

    always_comb begin
        tick  = (div_q == '0);
        div_d = tick ? DIV_W'(DIV - 1) : div_q - DIV_W'(1);
        us_d  = us_q;
        sub_d = sub_q;
        cm_d  = cm_q;
        if (clear) begin
            us_d  = '0;
            sub_d = SUB_W'(US_PER_CM - 1);
            cm_d  = '0;
        end else if (tick) begin
            if (us_q != '1) begin
                us_d = us_q + US_W'(1);
            end
            // sub_q is a down-counter; its terminal count marks the 58th tick.
            if (count_en) begin
                if (sub_q == '0) begin
                    sub_d = SUB_W'(US_PER_CM - 1);
                    if (cm_q != '1) begin
                        cm_d = cm_q + DIST_W'(1);
                    end
                end else begin
                    sub_d = sub_q - SUB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= DIV_W'(DIV - 1);
            us_q  <= '0;
            sub_q <= SUB_W'(US_PER_CM - 1);
            cm_q  <= '0;
        end else begin
            div_q <= div_d;
            us_q  <= us_d;
            sub_q <= sub_d;
            cm_q  <= cm_d;
        end
    end

    assign us_cnt = us_q;
    assign cm     = cm_q;

endmodule

// File: rtl/ultrasonic_scan_n.sv
// Round-robin HC-SR04 ranging controller for N_CH sensors.
//   clk, reset_n : system clock, async active-low reset
//   enable       : 1 = scan, 0 = abort and park in IDLE
//   echo         : raw echo pins (asynchronous)
//   trigger      : trigger pins, one-hot or zero
//   distance     : per-channel range in cm, channel k at [k*DIST_W +: DIST_W]
//   timeout      : sticky per-channel flag, last attempt timed out
//   valid        : one-cycle strobe, channel ch_id finished
//   ch_id        : channel currently or last serviced
//   state_dbg    : FSM state
//
// state   | meaning
// IDLE    | parked, waiting for enable
// GAP     | quiet time before the selected channel fires
// TRIG    | trigger pin of ch_id high for TRIG_US
// WAIT_HI | waiting for the echo of ch_id to rise
// MEASURE | echo high, accumulating cm
// DONE    | publish distance, clear timeout flag, strobe valid
// TOUT    | keep distance, set timeout flag, strobe valid
// NEXT    | advance ch_id with wrap
module ultrasonic_scan_n
    import ultrasonic_scan_n_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int N_CH       = 4,
    parameter int DIST_W     = 12,
    parameter int TRIG_US    = 10,
    parameter int GAP_US     = 60_000,
    parameter int TIMEOUT_US = 30_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trigger,
    output logic [N_CH*DIST_W-1:0]   distance,
    output logic [N_CH-1:0]          timeout,
    output logic                     valid,
    output logic [CH_ID_W-1:0]       ch_id,
    output logic [2:0]               state_dbg
);

    localparam int US_MAX = max_int(max_int(GAP_US, TRIG_US), TIMEOUT_US);
    localparam int US_W   = $clog2(US_MAX + 1);

    logic [N_CH-1:0] echo_meta_q, echo_sync_q, echo_prev_q;
    logic [MAX_CH-1:0] rise_pad, fall_pad;
    logic rise_sel, fall_sel;

    logic              tick;
    logic [US_W-1:0]   us_cnt;
    logic [DIST_W-1:0] cm;
    logic              cnt_clear;
    logic              cnt_en;
    logic              gap_done, trig_done, tout_done;

    scan_state_e               state_q, state_d;
    logic [CH_ID_W-1:0]        ch_id_q, ch_id_d;
    logic [N_CH-1:0]           trigger_q, trigger_d;
    logic [N_CH*DIST_W-1:0]    distance_q, distance_d;
    logic [N_CH-1:0]           timeout_q, timeout_d;
    logic                      valid_q, valid_d;

    // Two-flop synchroniser plus one more stage for edge detection; an edge
    // on the pin acts on the FSM three clocks later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            echo_prev_q <= '0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
        end
    end

    // Widen to the full ch_id range so the mux index never exceeds the vector.
    always_comb begin
        rise_pad = '0;
        fall_pad = '0;
        for (int i = 0; i < N_CH; i++) begin
            rise_pad[i] = echo_sync_q[i] & ~echo_prev_q[i];
            fall_pad[i] = ~echo_sync_q[i] & echo_prev_q[i];
        end
        rise_sel = rise_pad[ch_id_q];
        fall_sel = fall_pad[ch_id_q];
    end

    us_cm_counter #(
        .CLK_HZ (CLK_HZ),
        .US_W   (US_W),
        .DIST_W (DIST_W)
    ) u_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (cnt_clear),
        .count_en (cnt_en),
        .tick     (tick),
        .us_cnt   (us_cnt),
        .cm       (cm)
    );

    // Expiry fires on the tick that completes the interval.
    assign gap_done  = tick && (us_cnt == US_W'(GAP_US - 1));
    assign trig_done = tick && (us_cnt == US_W'(TRIG_US - 1));
    assign tout_done = tick && (us_cnt == US_W'(TIMEOUT_US - 1));
    assign cnt_en    = (state_q == S_MEASURE);

    always_comb begin
        state_d    = state_q;
        ch_id_d    = ch_id_q;
        distance_d = distance_q;
        timeout_d  = timeout_q;
        valid_d    = 1'b0;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_GAP;
                S_GAP:     if (gap_done) state_d = S_TRIG;
                S_TRIG:    if (trig_done) state_d = S_WAIT_HI;
                S_WAIT_HI: begin
                    if (rise_sel) state_d = S_MEASURE;
                    else if (tout_done) state_d = S_TOUT;
                end
                S_MEASURE: begin
                    if (fall_sel) state_d = S_DONE;
                    else if (tout_done) state_d = S_TOUT;
                end
                S_DONE: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (CH_ID_W'(i) == ch_id_q) begin
                            distance_d[i*DIST_W +: DIST_W] = cm;
                            timeout_d[i] = 1'b0;
                        end
                    end
                    valid_d = 1'b1;
                    state_d = S_NEXT;
                end
                S_TOUT: begin
                    for (int i = 0; i < N_CH; i++) begin
                        if (CH_ID_W'(i) == ch_id_q) timeout_d[i] = 1'b1;
                    end
                    valid_d = 1'b1;
                    state_d = S_NEXT;
                end
                S_NEXT: begin
                    ch_id_d = (ch_id_q == CH_ID_W'(N_CH - 1)) ? '0 : ch_id_q + CH_ID_W'(1);
                    state_d = S_GAP;
                end
                default:   state_d = S_IDLE;
            endcase
        end

        trigger_d = '0;
        if (state_d == S_TRIG) begin
            for (int i = 0; i < N_CH; i++) begin
                if (CH_ID_W'(i) == ch_id_q) trigger_d[i] = 1'b1;
            end
        end

        // Counters restart on entry to every timed state; DONE must still see cm.
        cnt_clear = (state_d != state_q) &&
                    (state_d inside {S_GAP, S_TRIG, S_WAIT_HI, S_MEASURE});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            ch_id_q    <= '0;
            trigger_q  <= '0;
            distance_q <= '0;
            timeout_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_id_q    <= ch_id_d;
            trigger_q  <= trigger_d;
            distance_q <= distance_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
        end
    end

    assign trigger   = trigger_q;
    assign distance  = distance_q;
    assign timeout   = timeout_q;
    assign valid     = valid_q;
    assign ch_id     = ch_id_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_ultrasonic_scan_n.sv
// Directed bench for ultrasonic_scan_n: 1 MHz clock so one tick per clock,
// GAP 100, TRIG 10, TIMEOUT 3000. A second instance with DIST_W=4, N_CH=1
// covers distance saturation.
module tb_ultrasonic_scan_n;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_MEASURE = 3'd4;
    localparam logic [2:0] ST_TOUT    = 3'd6;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  echo = '0;
    logic [3:0]  trigger;
    logic [47:0] distance;
    logic [3:0]  timeout;
    logic        valid;
    logic [2:0]  ch_id;
    logic [2:0]  state_dbg;

    logic        enable2 = 1'b0;
    logic [0:0]  echo2 = '0;
    logic [0:0]  trigger2;
    logic [3:0]  distance2;
    logic [0:0]  timeout2;
    logic        valid2;
    logic [2:0]  ch_id2;
    logic [2:0]  state_dbg2;

    int n_checks = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    bit multi_trig = 1'b0;

    always #5 clk = ~clk;

    ultrasonic_scan_n #(
        .CLK_HZ(1_000_000), .N_CH(4), .DIST_W(12),
        .TRIG_US(10), .GAP_US(100), .TIMEOUT_US(3000)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .echo(echo),
        .trigger(trigger), .distance(distance), .timeout(timeout),
        .valid(valid), .ch_id(ch_id), .state_dbg(state_dbg)
    );

    ultrasonic_scan_n #(
        .CLK_HZ(1_000_000), .N_CH(1), .DIST_W(4),
        .TRIG_US(10), .GAP_US(100), .TIMEOUT_US(3000)
    ) dut_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable2), .echo(echo2),
        .trigger(trigger2), .distance(distance2), .timeout(timeout2),
        .valid(valid2), .ch_id(ch_id2), .state_dbg(state_dbg2)
    );

    always @(negedge clk) begin
        if (valid === 1'b1) valid_cnt++;
        if ($countones(trigger) > 1) multi_trig = 1'b1;
    end

    task automatic apply_reset();
        reset_n = 1'b0; enable = 1'b0; enable2 = 1'b0; echo = '0; echo2 = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the first negedge with trigger[ch] low again.
    task automatic wait_trigger(input logic [1:0] ch, output bit ok, output int width);
        int n;
        n = 0; width = 0;
        while (trigger[ch] !== 1'b1 && n < 4000) begin @(negedge clk); n++; end
        ok = (trigger[ch] === 1'b1);
        if (ok) while (trigger[ch] === 1'b1 && width < 100) begin @(negedge clk); width++; end
    endtask

    task automatic pulse_echo(input logic [1:0] ch, input int delay, input int width);
        repeat (delay) @(negedge clk);
        echo[ch] = 1'b1;
        repeat (width) @(negedge clk);
        echo[ch] = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok, output int n);
        n = 0;
        while (valid !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        ok = (valid === 1'b1);
    endtask

    task automatic service(input logic [1:0] ch, input int delay, input int width, output bit ok);
        bit t_ok, v_ok;
        int w, n;
        wait_trigger(ch, t_ok, w);
        v_ok = 1'b0;
        if (t_ok) begin
            pulse_echo(ch, delay, width);
            wait_valid(20, v_ok, n);
        end
        ok = t_ok && v_ok;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (trigger !== 4'b0) begin n_fail++; $display("FAIL reset_trigger: got %b want 0000", trigger); end
        n_checks++; if (distance !== 48'd0) begin n_fail++; $display("FAIL reset_distance: got %h want 0", distance); end
        n_checks++; if (timeout !== 4'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0000", timeout); end
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_checks++; if (ch_id !== 3'd0) begin n_fail++; $display("FAIL reset_ch_id: got %0d want 0", ch_id); end
        n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++; if (state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL idle_while_disabled: got %0d want 0", state_dbg); end
    endtask

    task automatic test_single();
        bit ok; int w, n;
        apply_reset();
        enable = 1'b1;
        wait_trigger(2'd0, ok, w);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_trigger_seen: got none want trigger[0]"); end
        n_checks++; if (w !== 10) begin n_fail++; $display("FAIL single_trigger_width: got %0d want 10", w); end
        pulse_echo(2'd0, 200, 580);
        wait_valid(20, ok, n);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_valid_seen: got none want pulse"); end
        n_checks++; if (n !== 4) begin n_fail++; $display("FAIL single_fall_to_valid: got %0d want 4", n); end
        n_checks++; if (ch_id !== 3'd0) begin n_fail++; $display("FAIL single_ch_id: got %0d want 0", ch_id); end
        n_checks++; if (distance[11:0] !== 12'd10) begin n_fail++; $display("FAIL single_distance: got %0d want 10", distance[11:0]); end
        n_checks++; if (timeout[0] !== 1'b0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", timeout[0]); end
        @(negedge clk);
        n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_width: got %b want 0", valid); end
    endtask

    task automatic test_round_robin();
        bit ok; int n; logic [3:0] first;
        apply_reset();
        enable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            service(2'(c), 30, 58 * (c + 1), ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_service ch%0d: got no valid want valid", c); end
            n_checks++; if (ch_id !== 3'(c)) begin n_fail++; $display("FAIL rr_ch_id: got %0d want %0d", ch_id, c); end
            n_checks++; if (distance[c*12 +: 12] !== 12'(c + 1)) begin n_fail++; $display("FAIL rr_distance ch%0d: got %0d want %0d", c, distance[c*12 +: 12], c + 1); end
            @(negedge clk);
        end
        n = 0;
        while (trigger === 4'b0 && n < 300) begin @(negedge clk); n++; end
        first = trigger;
        n_checks++; if (first !== 4'b0001) begin n_fail++; $display("FAIL rr_wrap_trigger: got %b want 0001", first); end
        n_checks++; if (ch_id !== 3'd0) begin n_fail++; $display("FAIL rr_wrap_ch_id: got %0d want 0", ch_id); end
        n_checks++; if (multi_trig !== 1'b0) begin n_fail++; $display("FAIL rr_one_hot_trigger: got %b want 0", multi_trig); end
    endtask

    task automatic test_timeout();
        bit ok; int w, n;
        apply_reset();
        enable = 1'b1;
        // pass 1: ch2 reads 2 cm
        service(2'd0, 30, 58, ok);
        service(2'd1, 30, 58, ok);
        service(2'd2, 30, 116, ok);
        n_checks++; if (!ok || distance[35:24] !== 12'd2) begin n_fail++; $display("FAIL to_pass1_distance: got %0d want 2", distance[35:24]); end
        service(2'd3, 30, 58, ok);
        // pass 2: ch2 silent
        service(2'd0, 30, 58, ok);
        service(2'd1, 30, 58, ok);
        wait_trigger(2'd2, ok, w);
        n = 0;
        while (state_dbg !== ST_TOUT && n < 3200) begin @(negedge clk); n++; end
        n_checks++; if (n !== 3000) begin n_fail++; $display("FAIL to_expiry_time: got %0d want 3000", n); end
        @(negedge clk);
        n_checks++; if (timeout[2] !== 1'b1) begin n_fail++; $display("FAIL to_flag_set: got %b want 1", timeout[2]); end
        n_checks++; if (valid !== 1'b1 || ch_id !== 3'd2) begin n_fail++; $display("FAIL to_valid: got valid=%b ch=%0d want 1/2", valid, ch_id); end
        n_checks++; if (distance[35:24] !== 12'd2) begin n_fail++; $display("FAIL to_distance_kept: got %0d want 2", distance[35:24]); end
        service(2'd3, 30, 58, ok);
        // pass 3: ch2 recovers
        service(2'd0, 30, 58, ok);
        service(2'd1, 30, 58, ok);
        service(2'd2, 30, 290, ok);
        n_checks++; if (!ok || distance[35:24] !== 12'd5) begin n_fail++; $display("FAIL to_pass3_distance: got %0d want 5", distance[35:24]); end
        n_checks++; if (timeout[2] !== 1'b0) begin n_fail++; $display("FAIL to_flag_cleared: got %b want 0", timeout[2]); end
    endtask

    task automatic test_saturate();
        int widths [2] = '{812, 1200};
        int expect_cm [2] = '{14, 15};
        int n;
        apply_reset();
        enable2 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (trigger2[0] !== 1'b1 && n < 400) begin @(negedge clk); n++; end
            while (trigger2[0] === 1'b1 && n < 400) begin @(negedge clk); n++; end
            repeat (20) @(negedge clk);
            echo2[0] = 1'b1;
            repeat (widths[k]) @(negedge clk);
            echo2[0] = 1'b0;
            n = 0;
            while (valid2 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
            n_checks++; if (valid2 !== 1'b1) begin n_fail++; $display("FAIL sat_valid %0d: got none want pulse", k); end
            n_checks++; if (distance2 !== 4'(expect_cm[k])) begin n_fail++; $display("FAIL sat_distance %0d: got %0d want %0d", k, distance2, expect_cm[k]); end
            n_checks++; if (timeout2[0] !== 1'b0) begin n_fail++; $display("FAIL sat_timeout %0d: got %b want 0", k, timeout2[0]); end
            @(negedge clk);
        end
        enable2 = 1'b0;
    endtask

    task automatic test_abort();
        bit ok; int w, n, vc; logic [3:0] first;
        apply_reset();
        enable = 1'b1;
        service(2'd0, 30, 58, ok);
        wait_trigger(2'd1, ok, w);
        repeat (20) @(negedge clk);
        echo[1] = 1'b1;
        repeat (50) @(negedge clk);
        n_checks++; if (state_dbg !== ST_MEASURE) begin n_fail++; $display("FAIL abort_in_measure: got %0d want 4", state_dbg); end
        vc = valid_cnt;
        enable = 1'b0;
        @(negedge clk);
        n_checks++; if (state_dbg !== ST_IDLE || trigger !== 4'b0) begin n_fail++; $display("FAIL abort_next_clk: got state=%0d trig=%b want 0/0000", state_dbg, trigger); end
        repeat (20) @(negedge clk);
        echo[1] = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (valid_cnt !== vc) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses want %0d", valid_cnt, vc); end
        n_checks++; if (ch_id !== 3'd1) begin n_fail++; $display("FAIL abort_ch_kept: got %0d want 1", ch_id); end
        n_checks++; if (distance[23:12] !== 12'd0 || timeout[1] !== 1'b0) begin n_fail++; $display("FAIL abort_no_update: got d=%0d t=%b want 0/0", distance[23:12], timeout[1]); end
        enable = 1'b1;
        n = 0;
        while (trigger === 4'b0 && n < 300) begin @(negedge clk); n++; end
        first = trigger;
        n_checks++; if (first !== 4'b0010) begin n_fail++; $display("FAIL abort_resume_ch: got %b want 0010", first); end
        service(2'd1, 30, 174, ok);
        n_checks++; if (!ok || distance[23:12] !== 12'd3) begin n_fail++; $display("FAIL abort_remeasure: got %0d want 3", distance[23:12]); end
    endtask

    task automatic test_early_echo();
        bit ok; int w, n;
        apply_reset();
        echo[0] = 1'b1;
        enable = 1'b1;
        wait_trigger(2'd0, ok, w);
        repeat (100) @(negedge clk);
        echo[2] = 1'b1;
        repeat (30) @(negedge clk);
        echo[2] = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (state_dbg !== ST_WAIT_HI) begin n_fail++; $display("FAIL early_other_ch_ignored: got %0d want 3", state_dbg); end
        n = 0;
        while (timeout[0] !== 1'b1 && n < 3200) begin @(negedge clk); n++; end
        n_checks++; if (timeout[0] !== 1'b1) begin n_fail++; $display("FAIL early_high_times_out: got %b want 1", timeout[0]); end
        n_checks++; if (distance[11:0] !== 12'd0 || ch_id !== 3'd0) begin n_fail++; $display("FAIL early_outputs: got d=%0d ch=%0d want 0/0", distance[11:0], ch_id); end
        echo[0] = 1'b0;
    endtask

    task automatic test_reset_mid_trig();
        bit ok; int n;
        apply_reset();
        enable = 1'b1;
        service(2'd0, 30, 580, ok);
        n_checks++; if (!ok || distance[11:0] !== 12'd10) begin n_fail++; $display("FAIL rst_pre_distance: got %0d want 10", distance[11:0]); end
        n = 0;
        while (trigger[1] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        n_checks++; if (trigger !== 4'b0010) begin n_fail++; $display("FAIL rst_in_trig: got %b want 0010", trigger); end
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if (trigger !== 4'b0) begin n_fail++; $display("FAIL rst_async_trigger: got %b want 0000", trigger); end
        n_checks++; if (distance !== 48'd0) begin n_fail++; $display("FAIL rst_async_distance: got %h want 0", distance); end
        n_checks++; if (ch_id !== 3'd0 || state_dbg !== ST_IDLE) begin n_fail++; $display("FAIL rst_async_ch_state: got ch=%0d st=%0d want 0/0", ch_id, state_dbg); end
        @(negedge clk);
        reset_n = 1'b1;
        enable = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_saturate();
        test_abort();
        test_early_echo();
        test_reset_mid_trig();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
